// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the accumulation result reader
package rf_pkg;

  // Reader sequencing: wait for an update, walk the label registers, hand the result to the FIFO
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PUSH = 2'd2
  } rf_state_t;

  // Result words carry one extra tag bit: 1 = classification label, 0 = regression mean
  localparam int TAG_W = 1;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word-fall-through result queue with occupancy counter
module result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // The counter, not the pointers, tells full from empty since the pointers wrap onto each other
  assign full      = (count == CW'(DEPTH));
  assign valid     = (count != '0);
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & valid & ~flush;
  // Head is forced to zero when empty so the outputs read as zero out of reset
  assign head_data = valid ? mem[rd_ptr] : '0;

  // Storage array: written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accum_result_reader.sv
// rtl/accum_result_reader.sv - turns accumulator updates into argmax labels or regression means
module accum_result_reader
  import rf_pkg::*;
#(
  parameter int N_LABELS   = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_LABELS*FIFO_WIDTH-1:0] i_clf_accum_reg,
  input  logic [N_LABELS-1:0]            i_clf_accum_reg_vld,
  input  logic [FIFO_WIDTH-1:0]          i_rgs_accum_reg,
  input  logic                           i_rgs_accum_reg_vld,
  input  logic [$clog2(FIFO_WIDTH)-1:0]  i_n_trees_log2,
  input  logic                           i_flush,
  output logic [FIFO_WIDTH-1:0]          o_res_data,
  output logic                           o_res_is_clf,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic                           o_busy,
  output logic                           o_drop
);

  localparam int IW = (N_LABELS > 1) ? $clog2(N_LABELS) : 1;
  localparam int RW = FIFO_WIDTH + TAG_W;

  rf_state_t              state;
  rf_state_t              next_state;
  logic [FIFO_WIDTH-1:0]  snap [N_LABELS];
  logic [IW-1:0]          scan_idx;
  logic [IW-1:0]          best_idx;
  logic [FIFO_WIDTH-1:0]  best_val;
  logic [FIFO_WIDTH-1:0]  mean;
  logic                   res_is_clf;
  logic                   drop_q;

  logic                   clf_evt;
  logic                   any_evt;
  logic                   busy;
  logic                   accept_clf;
  logic                   accept_rgs;
  logic                   drop_evt;
  logic                   scan_last;
  logic [FIFO_WIDTH-1:0]  cur_val;
  logic                   fifo_push;
  logic                   fifo_full;
  logic [RW-1:0]          fifo_wdata;
  logic [RW-1:0]          fifo_head;

  assign clf_evt = |i_clf_accum_reg_vld;
  assign any_evt = clf_evt | i_rgs_accum_reg_vld;
  assign cur_val = snap[scan_idx];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: flush always returns to idle; push waits for room in the FIFO
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clf_evt) begin
            next_state = ST_SCAN;
          end else if (i_rgs_accum_reg_vld) begin
            next_state = ST_PUSH;
          end
        end
        ST_SCAN: begin
          if (scan_last) begin
            next_state = ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!fifo_full) begin
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Per-state control decodes; classification wins over regression in the same idle cycle
  always_comb begin
    busy       = (state != ST_IDLE);
    scan_last  = (state == ST_SCAN) && (scan_idx == IW'(N_LABELS - 1));
    accept_clf = !busy && clf_evt && !i_flush;
    accept_rgs = !busy && !clf_evt && i_rgs_accum_reg_vld && !i_flush;
    drop_evt   = (busy && any_evt) || (!busy && clf_evt && i_rgs_accum_reg_vld);
    fifo_push  = (state == ST_PUSH) && !fifo_full && !i_flush;
  end

  // Snapshot, argmax walk and regression mean; strict compare keeps the lowest index on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_LABELS; k++) begin
        snap[k] <= '0;
      end
      scan_idx   <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      mean       <= '0;
      res_is_clf <= 1'b0;
    end else if (accept_clf) begin
      for (int k = 0; k < N_LABELS; k++) begin
        snap[k] <= i_clf_accum_reg[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
      scan_idx   <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      res_is_clf <= 1'b1;
    end else if (accept_rgs) begin
      mean       <= $signed(i_rgs_accum_reg) >>> i_n_trees_log2;
      res_is_clf <= 1'b0;
    end else if ((state == ST_SCAN) && !i_flush) begin
      if (cur_val > best_val) begin
        best_val <= cur_val;
        best_idx <= scan_idx;
      end
      scan_idx <= scan_idx + IW'(1);
    end
  end

  // Sticky drop flag: set by any discarded update, cleared only by flush or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (i_flush) begin
      drop_q <= 1'b0;
    end else if (drop_evt) begin
      drop_q <= 1'b1;
    end
  end

  assign fifo_wdata = {res_is_clf, res_is_clf ? FIFO_WIDTH'(best_idx) : mean};

  result_fifo #(
    .WIDTH (RW),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (i_res_ready),
    .head_data (fifo_head),
    .valid     (o_res_valid),
    .full      (fifo_full)
  );

  assign o_res_data   = fifo_head[FIFO_WIDTH-1:0];
  assign o_res_is_clf = fifo_head[RW-1];
  assign o_busy       = busy;
  assign o_drop       = drop_q;

endmodule
